// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: FSM state codes, flash
// opcodes, dummy-cycle count and a byte-lane selector.
package spi_flash_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DUMMY  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [7:0] CMD_READ       = 8'h03;
    localparam logic [7:0] CMD_FASTREAD   = 8'h0B;
    localparam logic [7:0] CMD_PD         = 8'hB9;
    localparam logic [7:0] CMD_RELEASE_PD = 8'hAB;
    localparam logic [7:0] CMD_RESET_CONT = 8'hFF;

    localparam int DUMMY_CYCLES = 8;

    // Little-endian lane pick: lane 0 is bits [7:0].
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for the SPI pins. The SPI clock gets rise/fall
// pulses derived from its synchronized level; the other pins (chip select,
// mosi) travel through an identical flop chain so they stay aligned with
// the clock edges.
module spi_sync_edge #(
    parameter int               WIDTH      = 1,
    parameter int               STAGES     = 2,
    parameter logic [WIDTH-1:0] DATA_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_q,
    output logic             rise,
    output logic             fall
);

    logic [STAGES-1:0] sclk_pipe;
    logic [WIDTH-1:0]  data_pipe [STAGES];
    logic              sclk_prev;

    // Shift all pins through the synchronizer chain and keep the previous clock level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_pipe <= '0;
            sclk_prev <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                data_pipe[i] <= DATA_RESET;
            end
        end else begin
            sclk_pipe    <= {sclk_pipe[STAGES-2:0], sclk_in};
            sclk_prev    <= sclk_pipe[STAGES-1];
            data_pipe[0] <= data_in;
            for (int i = 1; i < STAGES; i++) begin
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign data_q = data_pipe[STAGES-1];
    assign rise   = sclk_pipe[STAGES-1] & ~sclk_prev;
    assign fall   = ~sclk_pipe[STAGES-1] & sclk_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// Single-SPI (mode 0) flash target backed by a word-wide valid/ready read
// port. Serves READ (0x03), deep power-down (0xB9) and release (0xAB).
// Data words are double-buffered, indexed by word-address parity, so the
// next word can be fetched while the current one is still shifting.
// Build option SPI_FLASH_RESPONDER_FASTREAD_EN enables FAST READ (0x0B)
// with eight dummy clocks; without it 0x0B is ignored like any unknown opcode.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_csb,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    output logic        spi_miso_do,
    output logic        spi_miso_oe,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        powered_down,
    output logic        underrun
);

    logic [1:0]  sync_data;
    logic        csb_s;
    logic        mosi_s;
    logic        sclk_rise;
    logic        sclk_fall;

    logic [2:0]  state;
    logic [4:0]  bit_cnt;
    logic [22:0] shift_in;
    logic [23:0] addr;
    logic        fast_rd;
    logic [2:0]  data_bit;
    logic [7:0]  out_shift;

    logic [31:0] word_buf [2];
    logic [1:0]  buf_vld;
    logic [21:0] fetch_waddr;
    logic        discard;

    logic [7:0]  opcode;
    logic [23:0] addr_word;
    logic [21:0] cur_waddr;
    logic [21:0] next_waddr;
    logic        cur_p;
    logic [7:0]  cur_byte;
    logic        fetch_live;
    logic        prefetch_ok;
    logic        consume_word;

    spi_sync_edge #(
        .WIDTH      (2),
        .STAGES     (SYNC_STAGES),
        .DATA_RESET (2'b01)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .sclk_in (spi_clk),
        .data_in ({spi_mosi, spi_csb}),
        .data_q  (sync_data),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    assign csb_s  = sync_data[0];
    assign mosi_s = sync_data[1];

    assign opcode       = {shift_in[6:0], mosi_s};
    assign addr_word    = {shift_in, mosi_s};
    assign cur_waddr    = addr[23:2];
    assign next_waddr   = cur_waddr + 22'd1;
    assign cur_p        = cur_waddr[0];
    assign cur_byte     = lane_byte(word_buf[cur_p], addr[1:0]);
    assign fetch_live   = (state == ST_DATA) || (state == ST_DUMMY);
    assign prefetch_ok  = (state == ST_DATA) && (addr[1:0] == 2'd3) && (data_bit != 3'd0);
    assign consume_word = sclk_fall && (state == ST_DATA) && (data_bit == 3'd7) && (addr[1:0] == 2'd3);

    // Command/address/dummy/data sequencing driven by the synchronized SPI edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift_in     <= '0;
            addr         <= '0;
            fast_rd      <= 1'b0;
            data_bit     <= '0;
            out_shift    <= '0;
            spi_miso_do  <= 1'b0;
            spi_miso_oe  <= 1'b0;
            powered_down <= 1'b0;
            underrun     <= 1'b0;
        end else if (csb_s) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            data_bit    <= '0;
            spi_miso_oe <= 1'b0;
            spi_miso_do <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_CMD;
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_in <= {shift_in[21:0], mosi_s};
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            if (powered_down && (opcode != CMD_RELEASE_PD)) begin
                                state <= ST_IGNORE;
                            end else begin
                                case (opcode)
                                    CMD_READ: begin
                                        fast_rd <= 1'b0;
                                        state   <= ST_ADDR;
                                    end
                                    CMD_FASTREAD: begin
`ifdef SPI_FLASH_RESPONDER_FASTREAD_EN
                                        fast_rd <= 1'b1;
                                        state   <= ST_ADDR;
`else
                                        state   <= ST_IGNORE;
`endif
                                    end
                                    CMD_PD: begin
                                        powered_down <= 1'b1;
                                        state        <= ST_IGNORE;
                                    end
                                    CMD_RELEASE_PD: begin
                                        powered_down <= 1'b0;
                                        state        <= ST_IGNORE;
                                    end
                                    CMD_RESET_CONT, 8'h66, 8'h99: begin
                                        state <= ST_IGNORE;
                                    end
                                    default: begin
                                        state <= ST_IGNORE;
                                    end
                                endcase
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        shift_in <= {shift_in[21:0], mosi_s};
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            addr    <= addr_word;
                            state   <= fast_rd ? ST_DUMMY : ST_DATA;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(DUMMY_CYCLES - 1)) begin
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_fall) begin
                        spi_miso_oe <= 1'b1;
                        if (data_bit == 3'd0) begin
                            if (buf_vld[cur_p]) begin
                                spi_miso_do <= cur_byte[7];
                                out_shift   <= {cur_byte[6:0], 1'b0};
                            end else begin
                                spi_miso_do <= 1'b0;
                                out_shift   <= '0;
                                underrun    <= 1'b1;
                            end
                            data_bit <= 3'd1;
                        end else begin
                            spi_miso_do <= out_shift[7];
                            out_shift   <= {out_shift[6:0], 1'b0};
                            data_bit    <= data_bit + 3'd1;
                            if (data_bit == 3'd7) begin
                                addr <= addr + 24'd1;
                            end
                        end
                    end
                end
                ST_IGNORE: begin
                    state <= ST_IGNORE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Single-outstanding fetch engine: fill the current word first, then the next one once lane 3 is shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid   <= 1'b0;
            mem_addr    <= '0;
            fetch_waddr <= '0;
            discard     <= 1'b0;
            buf_vld     <= '0;
            word_buf[0] <= '0;
            word_buf[1] <= '0;
        end else begin
            if (mem_valid) begin
                if (csb_s) begin
                    discard <= 1'b1;
                end
                if (mem_ready) begin
                    mem_valid <= 1'b0;
                    discard   <= 1'b0;
                    if (!discard && !csb_s && fetch_live &&
                        ((fetch_waddr == cur_waddr) || (fetch_waddr == next_waddr))) begin
                        word_buf[fetch_waddr[0]] <= mem_rdata;
                        buf_vld[fetch_waddr[0]]  <= 1'b1;
                    end
                end
            end else if (fetch_live && !csb_s) begin
                if (!buf_vld[cur_p]) begin
                    mem_valid   <= 1'b1;
                    fetch_waddr <= cur_waddr;
                    mem_addr    <= MEM_BASE + {8'h00, cur_waddr, 2'b00};
                end else if (prefetch_ok && !buf_vld[~cur_p]) begin
                    mem_valid   <= 1'b1;
                    fetch_waddr <= next_waddr;
                    mem_addr    <= MEM_BASE + {8'h00, next_waddr, 2'b00};
                end
            end
            if (consume_word) begin
                buf_vld[cur_p] <= 1'b0;
            end
            if (csb_s) begin
                buf_vld <= '0;
            end
        end
    end

endmodule
